// File: rtl/adc_capture_regfile_if.sv
// APB bundle between the APB/MDIO bridge (master) and adc_capture_regfile (slave).
interface adc_capture_regfile_if;
    logic [20:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/adc_capture_regfile.sv
// APB register file for the ADC capture path: config, command pulses, status, sample read-out.
// Optional ADC_CAPTURE_SIGN_EXT_EN: CFG bit [RCNT_W] selects sign extension of samples (reset 1).
module adc_capture_regfile #(
    parameter int          NCH       = 96,
    parameter int          DW        = 9,
    parameter int          RCNT_W    = 4,
    parameter int          BADDR_W   = 15,
    parameter logic [20:0] DATA_ADDR = 21'h7FFF
) (
    input  logic                  clk,
    input  logic                  rstn,
    adc_capture_regfile_if.slave  apb,
    output logic [RCNT_W-1:0]     cfg_rd_cnt,
    output logic                  write_pls,
    output logic                  read_pls,
    input  logic                  write_done,
    input  logic                  read_done,
    input  logic                  mdio_read_done,
    input  logic [NCH*DW-1:0]     smp_dout,
    output logic                  mdio_read,
    output logic [BADDR_W-1:0]    mdio_raddr
);

    localparam logic [20:0] A_CFG    = 21'h00000;
    localparam logic [20:0] A_CMD    = 21'h00001;
    localparam logic [20:0] A_STATUS = 21'h00002;
    localparam logic [20:0] A_PTR    = 21'h00003;
    localparam logic [20:0] A_BLK    = 21'h00004;
    localparam logic [6:0]  PTR_LAST = 7'(NCH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_RESP} state_t;

    state_t              state_r;
    logic [6:0]          ch_ptr_r;
    logic [BADDR_W-1:0]  blk_r;
    logic [RCNT_W-1:0]   cfg_r;
    logic                sgn_r;
    logic [2:0]          stat_r;
    logic                ovr_r;
    logic [1:0]          ovr_win_r;
    logic                write_pls_r;
    logic                read_pls_r;
    logic                mdio_read_r;
    logic [15:0]         prdata_r;
    logic                pready_r;
    logic                pslverr_r;

    logic                setup_s;
    logic                done_s;
    logic                data_rd_s;
    logic                is_cfg_s;
    logic                is_cmd_s;
    logic                is_stat_s;
    logic                is_ptr_s;
    logic                is_blk_s;
    logic                is_data_s;
    logic                reg_err_s;
    logic [15:0]         rd_val_s;
    logic [DW-1:0]       sample_s;
    logic [15:0]         sample_ext_s;

    // Extend a DW-bit sample to 16 bits, replicating the top bit when sgn is set.
    function automatic logic [15:0] ext16(input logic [DW-1:0] s, input logic sgn);
        logic [15:0] r;
        r = 16'h0000;
        for (int b = 0; b < DW; b++) begin
            r[b] = s[b];
        end
        for (int b = DW; b < 16; b++) begin
            r[b] = sgn & s[DW-1];
        end
        return r;
    endfunction

    assign setup_s   = apb.psel & ~apb.penable;
    assign done_s    = apb.psel & apb.penable & pready_r;
    assign is_cfg_s  = (apb.paddr == A_CFG);
    assign is_cmd_s  = (apb.paddr == A_CMD);
    assign is_stat_s = (apb.paddr == A_STATUS);
    assign is_ptr_s  = (apb.paddr == A_PTR);
    assign is_blk_s  = (apb.paddr == A_BLK);
    assign is_data_s = (apb.paddr == DATA_ADDR);
    assign data_rd_s = is_data_s & ~apb.pwrite;

    // Register read mux and error decode, evaluated in the setup phase.
    always_comb begin
        rd_val_s  = 16'h0000;
        reg_err_s = 1'b0;
        if (is_cfg_s) begin
            rd_val_s[RCNT_W-1:0] = cfg_r;
            rd_val_s[RCNT_W]     = sgn_r;
        end else if (is_cmd_s) begin
            rd_val_s = 16'h0000;
        end else if (is_stat_s) begin
            rd_val_s[3:0] = {ovr_r, stat_r};
        end else if (is_ptr_s) begin
            rd_val_s[6:0] = ch_ptr_r;
            reg_err_s     = apb.pwrite & (apb.pwdata >= 16'(NCH));
        end else if (is_blk_s) begin
            rd_val_s[BADDR_W-1:0] = blk_r;
        end else if (is_data_s) begin
            reg_err_s = apb.pwrite;
        end else begin
            reg_err_s = 1'b1;
        end
    end

    // Channel select of the current block.
    always_comb begin
        sample_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_ptr_r == 7'(i)) begin
                sample_s = smp_dout[i*DW +: DW];
            end else begin
                sample_s = sample_s;
            end
        end
    end

    assign sample_ext_s = ext16(sample_s, sgn_r);

    // Bus response, register writes, command pulses and the data-port FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            ch_ptr_r    <= 7'd0;
            blk_r       <= '0;
            cfg_r       <= '0;
`ifdef ADC_CAPTURE_SIGN_EXT_EN
            sgn_r       <= 1'b1;
`else
            sgn_r       <= 1'b0;
`endif
            stat_r      <= 3'b000;
            ovr_r       <= 1'b0;
            ovr_win_r   <= 2'd0;
            write_pls_r <= 1'b0;
            read_pls_r  <= 1'b0;
            mdio_read_r <= 1'b0;
            prdata_r    <= 16'h0000;
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
        end else begin
            write_pls_r <= 1'b0;
            read_pls_r  <= 1'b0;
            mdio_read_r <= 1'b0;
            stat_r      <= {mdio_read_done, read_done, write_done};
            if (ovr_win_r != 2'd0) begin
                ovr_win_r <= ovr_win_r - 2'd1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (setup_s && data_rd_s) begin
                        state_r <= ST_FETCH;
                        // Block reload still in flight: flag it but serve the stale block.
                        if (ovr_win_r != 2'd0) begin
                            ovr_r <= 1'b1;
                        end
                    end else if (setup_s) begin
                        pready_r  <= 1'b1;
                        pslverr_r <= reg_err_s;
                        prdata_r  <= reg_err_s ? 16'hFFFF : (apb.pwrite ? 16'h0000 : rd_val_s);
                    end else if (done_s) begin
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                        prdata_r  <= 16'h0000;
                        if (apb.pwrite && !pslverr_r) begin
                            if (is_cfg_s) begin
                                cfg_r <= apb.pwdata[RCNT_W-1:0];
`ifdef ADC_CAPTURE_SIGN_EXT_EN
                                sgn_r <= apb.pwdata[RCNT_W];
`endif
                            end else if (is_cmd_s) begin
                                write_pls_r <= apb.pwdata[0];
                                read_pls_r  <= apb.pwdata[1];
                            end else if (is_stat_s) begin
                                if (apb.pwdata[3]) begin
                                    ovr_r <= 1'b0;
                                end
                            end else if (is_ptr_s) begin
                                ch_ptr_r <= apb.pwdata[6:0];
                            end else if (is_blk_s) begin
                                blk_r <= apb.pwdata[BADDR_W-1:0];
                            end
                        end
                    end
                end
                ST_FETCH: begin
                    if (!apb.psel) begin
                        state_r <= ST_IDLE;
                    end else begin
                        prdata_r  <= sample_ext_s;
                        pready_r  <= 1'b1;
                        pslverr_r <= 1'b0;
                        state_r   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    pready_r <= 1'b0;
                    prdata_r <= 16'h0000;
                    if (ch_ptr_r == PTR_LAST) begin
                        ch_ptr_r    <= 7'd0;
                        mdio_read_r <= 1'b1;
                        blk_r       <= blk_r + BADDR_W'(1);
                        ovr_win_r   <= 2'd3;
                    end else begin
                        ch_ptr_r <= ch_ptr_r + 7'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    pready_r <= 1'b0;
                end
            endcase
        end
    end

    assign apb.prdata  = prdata_r;
    assign apb.pready  = pready_r;
    assign apb.pslverr = pslverr_r;
    assign cfg_rd_cnt  = cfg_r;
    assign write_pls   = write_pls_r;
    assign read_pls    = read_pls_r;
    assign mdio_read   = mdio_read_r;
    assign mdio_raddr  = blk_r;

endmodule

// File: tb/tb_adc_capture_regfile.sv
// Self-checking bench for adc_capture_regfile: register table, directed sequences, random data reads.
module tb_adc_capture_regfile;
    localparam int          NCH       = 96;
    localparam int          DW        = 9;
    localparam int          RCNT_W    = 4;
    localparam int          BADDR_W   = 15;
    localparam logic [20:0] DATA_ADDR = 21'h7FFF;
`ifdef ADC_CAPTURE_SIGN_EXT_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adc_capture_regfile_if apb();
    logic [RCNT_W-1:0]  cfg_rd_cnt;
    logic               write_pls, read_pls, mdio_read;
    logic               write_done = 1'b0, read_done = 1'b0, mdio_read_done = 1'b0;
    logic [NCH*DW-1:0]  smp_dout = '0;
    logic [BADDR_W-1:0] mdio_raddr;

    adc_capture_regfile #(.NCH(NCH), .DW(DW), .RCNT_W(RCNT_W), .BADDR_W(BADDR_W),
                          .DATA_ADDR(DATA_ADDR)) dut (
        .clk(clk), .rstn(rstn), .apb(apb.slave), .cfg_rd_cnt(cfg_rd_cnt),
        .write_pls(write_pls), .read_pls(read_pls), .write_done(write_done),
        .read_done(read_done), .mdio_read_done(mdio_read_done), .smp_dout(smp_dout),
        .mdio_read(mdio_read), .mdio_raddr(mdio_raddr)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, last_setup_cyc = 0, last_done_cyc = 0;
    int mr_seen = 0, wp_seen = 0, rp_seen = 0;

    // reference model state
    logic [DW-1:0] m_smp [NCH];
    int m_ptr = 0, m_blk = 0, m_mr_cnt = 0, mr_cyc = -100;
    bit m_ovr = 1'b0, m_sgn = SGN_EN;

    typedef struct {
        logic [20:0] addr; logic wr; logic [15:0] wd;
        logic [15:0] exp; logic exp_err; logic chk_data;
    } vec_t;
    vec_t tbl [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (mdio_read) mr_seen++;
            if (write_pls) wp_seen++;
            if (read_pls)  rp_seen++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic apb_xfer(input logic [20:0] addr, input logic wr, input logic [15:0] wd,
                            output logic [15:0] rd, output logic err, output int waits);
        @(posedge clk); #1;
        apb.paddr = addr; apb.pwrite = wr; apb.pwdata = wd;
        apb.psel = 1'b1; apb.penable = 1'b0;
        last_setup_cyc = cyc;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        waits = 0;
        while (apb.pready !== 1'b1 && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        if (apb.pready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL apb_timeout: addr %0h got no pready expected pready within 8 cycles", addr);
        end
        rd = apb.prdata; err = apb.pslverr; last_done_cyc = cyc;
    endtask

    task automatic rd_chk(input string nm, input logic [20:0] addr, input logic [15:0] exp);
        logic [15:0] rd; logic err; int w;
        apb_xfer(addr, 1'b0, 16'h0000, rd, err, w);
        chk(nm, rd, exp);
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_waits"}, w, 0);
    endtask

    task automatic wr_chk(input string nm, input logic [20:0] addr, input logic [15:0] wd,
                          input logic exp_err);
        logic [15:0] rd; logic err; int w;
        apb_xfer(addr, 1'b1, wd, rd, err, w);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_waits"}, w, 0);
    endtask

    function automatic logic [15:0] ext_model(input int v, input bit s);
        if (s && v >= (1 << (DW - 1))) return 16'(v + 65536 - (1 << DW));
        return 16'(v);
    endfunction

    task automatic set_smp();
        for (int i = 0; i < NCH; i++) smp_dout[i*DW +: DW] = m_smp[i];
    endtask

    task automatic data_read_chk(input string nm);
        logic [15:0] rd; logic err; int w;
        apb_xfer(DATA_ADDR, 1'b0, 16'h0000, rd, err, w);
        if (last_setup_cyc >= mr_cyc && last_setup_cyc - mr_cyc <= 2) m_ovr = 1'b1;
        chk(nm, rd, ext_model(int'(m_smp[m_ptr]), m_sgn));
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_waits"}, w, 1);
        if (m_ptr == NCH - 1) begin
            m_ptr = 0; m_blk = (m_blk + 1) % (1 << BADDR_W);
            m_mr_cnt++; mr_cyc = last_done_cyc + 1;
        end else begin
            m_ptr++;
        end
    endtask

    initial begin
        logic [15:0] rd; logic err; int w; int exp_wp, exp_rp;
        apb.paddr = 21'h0; apb.psel = 1'b0; apb.penable = 1'b0;
        apb.pwrite = 1'b0; apb.pwdata = 16'h0;
        for (int i = 0; i < NCH; i++) m_smp[i] = DW'(i);
        set_smp();

        tbl[0]  = '{21'h0, 1'b0, 16'h0000, SGN_EN ? 16'h0010 : 16'h0000, 1'b0, 1'b1};
        tbl[1]  = '{21'h2, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{21'h0, 1'b1, 16'h0015, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{21'h0, 1'b0, 16'h0000, SGN_EN ? 16'h0015 : 16'h0005, 1'b0, 1'b1};
        tbl[4]  = '{21'h1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[5]  = '{21'h3, 1'b1, 16'd96,   16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{21'h3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[7]  = '{21'h3, 1'b1, 16'd95,   16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{21'h3, 1'b0, 16'h0000, 16'd95,   1'b0, 1'b1};
        tbl[9]  = '{21'h5, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1};
        tbl[10] = '{DATA_ADDR, 1'b1, 16'h1234, 16'hFFFF, 1'b1, 1'b1};
        tbl[11] = '{21'h2, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[12] = '{21'h4, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0};
        tbl[13] = '{21'h4, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1};
        tbl[14] = '{21'h3, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[15] = '{21'h1FFFFF, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prdata", apb.prdata, 16'h0000);
        chk("rst_pready", apb.pready, 1'b0);
        chk("rst_pslverr", apb.pslverr, 1'b0);
        chk("rst_outs", {cfg_rd_cnt, write_pls, read_pls, mdio_read, mdio_raddr}, 32'h0);
        @(negedge clk); rstn = 1'b1;

        for (int k = 0; k < 16; k++) begin
            apb_xfer(tbl[k].addr, tbl[k].wr, tbl[k].wd, rd, err, w);
            chk($sformatf("tbl%0d_err", k), err, tbl[k].exp_err);
            chk($sformatf("tbl%0d_waits", k), w, 0);
            if (tbl[k].chk_data) chk($sformatf("tbl%0d_data", k), rd, tbl[k].exp);
        end
        chk("cfg_rd_cnt", cfg_rd_cnt, 4'h5);
        m_ptr = 0; m_blk = 16'h1234 % (1 << BADDR_W); m_sgn = SGN_EN;

        // command pulses: both bits, then a held write with only bit0
        wr_chk("cmd3", 21'h1, 16'h0003, 1'b0);
        idle();
        chk("cmd3_wp_hi", {write_pls, read_pls}, 2'b11);
        idle();
        chk("cmd3_wp_lo", {write_pls, read_pls}, 2'b00);
        wr_chk("cmd1_held", 21'h1, 16'h0001, 1'b0);
        @(posedge clk); #1;
        chk("cmd1_held_hi", {write_pls, read_pls}, 2'b10);
        @(posedge clk); #1;
        chk("cmd1_held_lo", {write_pls, read_pls}, 2'b00);
        idle();
        exp_wp = 2; exp_rp = 1;
        rd_chk("cmd_rd", 21'h1, 16'h0000);

        // status inputs pass through one register stage
        write_done = 1'b1; mdio_read_done = 1'b1;
        idle(); idle();
        rd_chk("status_in", 21'h2, 16'h0005);
        write_done = 1'b0; mdio_read_done = 1'b0;
        idle(); idle();

        // sequential walk of one block, channel i = i
        wr_chk("blk0", 21'h4, 16'h0000, 1'b0); m_blk = 0;
        for (int i = 0; i < NCH; i++) data_read_chk($sformatf("seq_%0d", i));
        rd_chk("blk_after", 21'h4, 16'h0001);
        rd_chk("ptr_after", 21'h3, 16'h0000);
        chk("mr_count1", mr_seen, m_mr_cnt);

        // block address wrap, then an overrun read one cycle after mdio_read
        wr_chk("blk_max", 21'h4, 16'h7FFF, 1'b0); m_blk = 32'h7FFF;
        for (int i = 0; i < NCH; i++) data_read_chk($sformatf("wrap_%0d", i));
        idle();
        data_read_chk("ovr_rd");
        rd_chk("ovr_set", 21'h2, 16'h0008);
        wr_chk("ovr_w1c", 21'h2, 16'h0008, 1'b0); m_ovr = 1'b0;
        rd_chk("ovr_clr", 21'h2, 16'h0000);
        rd_chk("blk_wrapped", 21'h4, 16'(m_blk));
        rd_chk("ptr_one", 21'h3, 16'h0001);

        // sample extension
        wr_chk("ptr0", 21'h3, 16'h0000, 1'b0); m_ptr = 0;
        m_smp[0] = 9'h1FF; set_smp();
        wr_chk("cfg_sgn", 21'h0, 16'h0010, 1'b0); m_sgn = SGN_EN;
        apb_xfer(DATA_ADDR, 1'b0, 16'h0000, rd, err, w);
        chk("sext_on", rd, SGN_EN ? 16'hFFFF : 16'h01FF);
        m_ptr = 1;
        wr_chk("cfg_nosgn", 21'h0, 16'h0000, 1'b0); m_sgn = 1'b0;
        wr_chk("ptr0b", 21'h3, 16'h0000, 1'b0); m_ptr = 0;
        data_read_chk("sext_off");
        idle(); idle(); idle();

        // random mix against the model
        for (int k = 0; k < 300; k++) begin
            int op, gap, v;
            gap = $urandom_range(0, 3);
            repeat (gap) idle();
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                if (op == 0) begin
                    for (int i = 0; i < NCH; i++) m_smp[i] = DW'($urandom_range(0, (1 << DW) - 1));
                    set_smp();
                end
                data_read_chk($sformatf("rnd_data_%0d", k));
            end else if (op == 6) begin
                v = $urandom_range(0, 127);
                wr_chk($sformatf("rnd_ptr_%0d", k), 21'h3, 16'(v), v >= NCH);
                if (v < NCH) m_ptr = v;
            end else if (op == 7) begin
                v = $urandom_range(0, (1 << BADDR_W) - 1);
                wr_chk($sformatf("rnd_blk_%0d", k), 21'h4, 16'(v), 1'b0);
                m_blk = v;
            end else if (op == 8) begin
                rd_chk($sformatf("rnd_stat_%0d", k), 21'h2, {12'h000, m_ovr, 3'b000});
                if ($urandom_range(0, 1) == 1) begin
                    wr_chk($sformatf("rnd_w1c_%0d", k), 21'h2, 16'h0008, 1'b0);
                    m_ovr = 1'b0;
                end
            end else begin
                v = $urandom_range(0, 65535);
                wr_chk($sformatf("rnd_cfg_%0d", k), 21'h0, 16'(v), 1'b0);
                m_sgn = SGN_EN & v[RCNT_W];
                rd_chk($sformatf("rnd_cfgrd_%0d", k), 21'h0,
                       {11'h000, m_sgn, 4'(v)});
            end
        end
        rd_chk("rnd_ptr_final", 21'h3, 16'(m_ptr));
        rd_chk("rnd_blk_final", 21'h4, 16'(m_blk));
        idle(); idle();
        chk("mr_count", mr_seen, m_mr_cnt);
        chk("wp_count", wp_seen, exp_wp);
        chk("rp_count", rp_seen, exp_rp);

        // reset during the response cycle of a data read
        @(posedge clk); #1;
        apb.paddr = DATA_ADDR; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
        @(posedge clk); #1; apb.penable = 1'b1;
        @(posedge clk); #1;
        chk("mid_pready_hi", apb.pready, 1'b1);
        rstn = 1'b0; #1;
        chk("mid_rst_pready", apb.pready, 1'b0);
        chk("mid_rst_raddr", mdio_raddr, 15'h0000);
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(negedge clk); rstn = 1'b1;
        rd_chk("mid_rst_ptr", 21'h3, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test expected finish before 2 ms");
        $fatal(1);
    end
endmodule
